seq_binary_to_bcd: RTL and testbench
====================================

SEQ_BINARY_TO_BCD -- requirements
Module: seq_binary_to_bcd

Interface
REQ-001 The module SHALL have parameter BIN_WIDTH, default 24, the unsigned binary input width (legal range 1..64).
REQ-002 The module SHALL have parameter DIGITS, default 8, the number of BCD output digits (legal range 1..20).
REQ-003 The module SHALL have port axis_aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port axis_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_binary is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the converter can accept a new value.
REQ-007 The module SHALL have port in_binary, input, BIN_WIDTH bits: unsigned value to convert.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The module SHALL have port out_bcd, output, 4*DIGITS bits: packed BCD, digit 0 (least significant) in bits [3:0].
REQ-011 The module SHALL have port out_ndigits, output, clog2(DIGITS+1) bits: count of significant digits, minimum 1.
REQ-012 The module SHALL have port out_overflow, output, 1 bit: the value does not fit in DIGITS digits.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 The block SHALL accept an input when in_valid and in_ready are both 1 on an edge: it latches in_binary into a shift register, clears the digit registers, clears the sticky overflow flag, loads an iteration counter with BIN_WIDTH, and moves to SHIFT.
REQ-015 Each SHIFT edge SHALL perform one double-dabble iteration: add 3 to every digit >=5, then shift {digits, binary} left by 1, with the binary MSB entering digit 0 bit 0.
REQ-016 If a 1 shifts out of digit DIGITS-1 bit 3 during an iteration, the overflow flag SHALL set and stay set until the next accept.
REQ-017 On the edge that performs iteration BIN_WIDTH, the FSM SHALL move to DONE; out_valid therefore rises exactly BIN_WIDTH edges after the accept edge.
REQ-018 In DONE, out_bcd, out_ndigits and out_overflow SHALL stay stable until the edge where out_valid and out_ready are both 1; that edge returns the FSM to IDLE.
REQ-019 No new input SHALL be accepted on the same edge that the output is consumed; throughput is one conversion per BIN_WIDTH+2 cycles.
REQ-020 out_ndigits SHALL equal the index of the most significant nonzero digit plus 1, and SHALL be 1 when all digits are 0.
REQ-021 On overflow, out_bcd SHALL equal the input value mod 10^DIGITS.
REQ-022 in_valid in any state other than IDLE SHALL be ignored, and in_binary SHALL not be sampled outside the accept edge.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 While axis_resetn=0, independent of the clock, the FSM SHALL be IDLE with out_valid=0, out_bcd=0, out_ndigits=1, out_overflow=0, the counter at 0, and in_ready=1.
REQ-025 A reset asserted in SHIFT or DONE SHALL abort the conversion and discard the result; the first edge after release may accept a new input.

Verification
REQ-026 The bench SHALL cover: defaults, accept 24'd0 -> after 24 edges out_valid=1, out_bcd=32'h00000000, out_ndigits=1, out_overflow=0.
REQ-027 The bench SHALL cover: defaults, accept 24'hFFFFFF -> out_bcd=32'h16777215, out_ndigits=8, out_overflow=0; accept 24'd12345 -> out_bcd=32'h00012345, out_ndigits=5.
REQ-028 The bench SHALL cover: BIN_WIDTH=10, DIGITS=3, accept 10'd1023 -> after 10 edges out_bcd=12'h023, out_overflow=1, out_ndigits=2.
REQ-029 The bench SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> outputs unchanged, in_ready=0; in_valid pulses with other data in that window are ignored; out_ready=1 -> IDLE on the next edge.
REQ-030 The bench SHALL cover reset mid-SHIFT: axis_resetn low at iteration 7 -> out_valid=0 and in_ready=1 immediately; a new conversion of 24'd999 after release -> out_bcd=32'h00000999, out_ndigits=3.
REQ-031 The bench SHALL cover back-to-back streaming: 100 random inputs with random out_ready -> each result matches a reference model, and no input is lost or duplicated.

Source files
------------

// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter using the double-dabble algorithm.
// It performs one shift per clock and uses a valid/ready handshake on both input and output.
module seq_binary_to_bcd #(
    parameter int BIN_WIDTH = 24,
    parameter int DIGITS    = 8
) (
    input  logic                          axis_aclk,
    input  logic                          axis_resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_WIDTH-1:0]          in_binary,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*DIGITS-1:0]           out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]   out_ndigits,
    output logic                          out_overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int ND_W  = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [4*DIGITS-1:0]  bcd_adj;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ND_W-1:0]      ndigits;

    // Add-3 correction so that each digit carries correctly on the following shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // NOTE: every signal gets a default before the case statement; a missing branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d   = in_binary;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The bit leaving the top digit stands for 10^DIGITS, which the digit registers cannot hold.
                bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_WIDTH-1]};
                ovf_d = ovf_q | bcd_adj[4*DIGITS-1];
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples its pre-edge inputs.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Significant-digit count: position of the highest nonzero digit, never less than one.
    always_comb begin
        ndigits = ND_W'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ndigits = ND_W'(i + 1);
            end
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_bcd      = bcd_q;
    assign out_ndigits  = ndigits;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Bench for seq_binary_to_bcd: directed cases on a 24-bit/8-digit instance and a 10-bit/3-digit instance,
// plus a randomized stream checked against an arithmetic decimal model.
module tb_seq_binary_to_bcd;

    localparam int AW = 24;
    localparam int AD = 8;
    localparam int BW = 10;
    localparam int BD = 3;

    logic axis_aclk   = 1'b0;
    logic axis_resetn = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_overflow;
    logic [AW-1:0]   a_in_binary;
    logic [4*AD-1:0] a_out_bcd;
    logic [3:0]      a_out_ndigits;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_overflow;
    logic [BW-1:0]   b_in_binary;
    logic [4*BD-1:0] b_out_bcd;
    logic [1:0]      b_out_ndigits;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0]   b_vals    [3] = '{10'd1023, 10'd999, 10'd1000};
    logic [4*BD-1:0] b_exp_bcd [3] = '{12'h023, 12'h999, 12'h000};
    int              b_exp_nd  [3] = '{2, 3, 1};
    logic            b_exp_ovf [3] = '{1'b1, 1'b0, 1'b1};

    seq_binary_to_bcd #(.BIN_WIDTH(AW), .DIGITS(AD)) dut_a (
        .axis_aclk   (axis_aclk),
        .axis_resetn (axis_resetn),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_binary   (a_in_binary),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_bcd     (a_out_bcd),
        .out_ndigits (a_out_ndigits),
        .out_overflow(a_out_overflow)
    );

    seq_binary_to_bcd #(.BIN_WIDTH(BW), .DIGITS(BD)) dut_b (
        .axis_aclk   (axis_aclk),
        .axis_resetn (axis_resetn),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_binary   (b_in_binary),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_bcd     (b_out_bcd),
        .out_ndigits (b_out_ndigits),
        .out_overflow(b_out_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    // Decimal reference: value mod 10^nd split into digits, overflow when the value reaches 10^nd.
    function automatic void model(input longint unsigned v, input int nd,
                                  output logic [79:0] bcd, output int ndig, output logic ovf);
        longint unsigned rem;
        longint unsigned lim;
        bcd  = '0;
        ndig = 1;
        rem  = v;
        lim  = 1;
        for (int i = 0; i < nd; i++) begin
            lim = lim * 10;
            bcd[4*i +: 4] = 4'(rem % 10);
            if (rem % 10 != 0) ndig = i + 1;
            rem = rem / 10;
        end
        ovf = (v >= lim);
    endfunction

    // Full conversion on the wide instance; garbage is presented on in_valid/in_binary while busy.
    task automatic run_a(input logic [AW-1:0] v, input logic [31:0] exp_bcd, input int exp_nd,
                         input logic exp_ovf, input string tag);
        int n;
        a_in_valid  = 1'b1;
        a_in_binary = v;
        check({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
        tick();
        check({tag, "_busy"}, 64'(a_in_ready), 64'd0);
        n = 0;
        while (!a_out_valid && n < 100) begin
            a_in_binary = AW'($urandom);
            tick();
            n++;
        end
        a_in_valid = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(AW));
        check({tag, "_bcd"}, 64'(a_out_bcd), 64'(exp_bcd));
        check({tag, "_ndigits"}, 64'(a_out_ndigits), 64'(exp_nd));
        check({tag, "_overflow"}, 64'(a_out_overflow), 64'(exp_ovf));
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check({tag, "_consumed"}, 64'(a_out_valid), 64'd0);
        check({tag, "_idle"}, 64'(a_in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n, sent, got, cyc, w, m_nd;
        logic [AW-1:0]    q[$];
        logic [79:0]      m_bcd;
        logic             m_ovf;
        longint unsigned  exp_v;

        a_in_valid = 1'b0; a_in_binary = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_binary = '0; b_out_ready = 1'b0;

        // Reset values, observed before any clock edge.
        #2;
        check("rst_in_ready",  64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_bcd",       64'(a_out_bcd), 64'd0);
        check("rst_ndigits",   64'(a_out_ndigits), 64'd1);
        check("rst_overflow",  64'(a_out_overflow), 64'd0);
        check("rst_b_ndigits", 64'(b_out_ndigits), 64'd1);
        tick();
        axis_resetn = 1'b1;
        tick();

        run_a(24'd0,       32'h00000000, 1, 1'b0, "zero");
        run_a(24'hFFFFFF,  32'h16777215, 8, 1'b0, "max");
        run_a(24'd12345,   32'h00012345, 5, 1'b0, "d12345");

        // Narrow instance: overflow wraps mod 1000 and the sticky flag clears on the next accept.
        for (int k = 0; k < 3; k++) begin
            b_in_valid  = 1'b1;
            b_in_binary = b_vals[k];
            tick();
            b_in_valid = 1'b0;
            n = 0;
            while (!b_out_valid && n < 100) begin
                tick();
                n++;
            end
            check("narrow_latency",  64'(n), 64'(BW));
            check("narrow_bcd",      64'(b_out_bcd), 64'(b_exp_bcd[k]));
            check("narrow_ndigits",  64'(b_out_ndigits), 64'(b_exp_nd[k]));
            check("narrow_overflow", 64'(b_out_overflow), 64'(b_exp_ovf[k]));
            b_out_ready = 1'b1;
            tick();
            b_out_ready = 1'b0;
            check("narrow_idle", 64'(b_in_ready), 64'd1);
        end

        // Backpressure in DONE with competing in_valid pulses.
        a_in_valid  = 1'b1;
        a_in_binary = 24'd654321;
        tick();
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_valid", 64'(a_out_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            a_in_valid  = (k % 2 == 0);
            a_in_binary = AW'($urandom);
            tick();
            check("bp_hold_bcd",   64'(a_out_bcd), 64'h00654321);
            check("bp_hold_nd",    64'(a_out_ndigits), 64'd6);
            check("bp_hold_valid", 64'(a_out_valid), 64'd1);
            check("bp_in_ready",   64'(a_in_ready), 64'd0);
        end
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_binary = 24'd42;
        tick();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        check("bp_consumed",        64'(a_out_valid), 64'd0);
        check("bp_no_same_edge_acc", 64'(a_in_ready), 64'd1);

        // Reset in the middle of SHIFT, then a fresh conversion.
        a_in_valid  = 1'b1;
        a_in_binary = 24'd123456;
        tick();
        a_in_valid = 1'b0;
        repeat (7) tick();
        check("mid_shift_busy", 64'(a_in_ready), 64'd0);
        #2;
        axis_resetn = 1'b0;
        #1;
        check("abort_out_valid", 64'(a_out_valid), 64'd0);
        check("abort_in_ready",  64'(a_in_ready), 64'd1);
        check("abort_bcd",       64'(a_out_bcd), 64'd0);
        tick();
        axis_resetn = 1'b1;
        run_a(24'd999, 32'h00000999, 3, 1'b0, "after_rst");

        // Randomized streaming with random out_ready against the decimal model.
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 20000) begin
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            w = $urandom_range(1, AW);
            a_in_binary = AW'($urandom) & AW'((64'd1 << w) - 64'd1);
            if (a_in_valid && a_in_ready) begin
                q.push_back(a_in_binary);
                sent++;
            end
            if (a_out_valid && a_out_ready) begin
                check("stream_pending", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    exp_v = 64'(q.pop_front());
                    model(exp_v, AD, m_bcd, m_nd, m_ovf);
                    check("stream_bcd",      64'(a_out_bcd), 64'(m_bcd[4*AD-1:0]));
                    check("stream_ndigits",  64'(a_out_ndigits), 64'(m_nd));
                    check("stream_overflow", 64'(a_out_overflow), 64'(m_ovf));
                end
                got++;
            end
            tick();
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        check("stream_results", 64'(got), 64'd100);
        check("stream_inputs",  64'(sent), 64'd100);
        check("stream_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
